fp_window_acc: RTL

- Sits directly downstream of the 12-bit linear to 8-bit float converter. It consumes its {S, E[2:0], F[3:0]} output words.
- Expands each float word back to a signed linear value: magnitude = F << E, sign from S.
- Accumulates a fixed window of 2^WIN_LOG2 samples and emits the signed window sum.
- Valid/ready handshakes on both sides, so it can sit behind a registered converter stage or a FIFO.

---
 rtl/fp_window_acc.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fp_window_acc.sv
// -----------------------------------------------------------------------------
// fp_window_acc
//
// Purpose:
//   Consumes 8-bit {S, E[2:0], F[3:0]} float words from the 12-bit linear to
//   8-bit float converter. Each word is expanded back to a signed linear value
//   (magnitude = F << E, negated when S=1). The block accumulates a fixed window
//   of 2^WIN_LOG2 samples and then emits the signed window result.
//
//   Both sides use valid/ready handshakes. Once a window completes, the result
//   is held until it is taken. While the result is held, the input side is
//   stalled, which costs one bubble cycle per window.
//
// Configuration:
//   WIN_LOG2              window length is 2^WIN_LOG2 samples (legal 1..8)
//   ACC_W                 local, 12 + WIN_LOG2; accumulator and output width
//   FP_WINDOW_ACC_MEAN_EN if defined, out_sum carries the floor mean of the
//                         window instead of the raw sum
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   float sample present
//   in_ready   out  sample accepted this cycle (depends only on state)
//   in_s       in   sign, 1 = negative
//   in_e       in   exponent
//   in_f       in   significand
//   out_valid  out  window result present
//   out_ready  in   downstream takes the result
//   out_sum    out  two's-complement window result, ACC_W bits
// -----------------------------------------------------------------------------
module fp_window_acc #(
  parameter  int WIN_LOG2 = 3,
  localparam int ACC_W    = 12 + WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [2:0]       in_e,
  input  logic [3:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic [WIN_LOG2-1:0]       r_count;
  logic                      r_out_valid;
  logic [ACC_W-1:0]          r_out_sum;
  logic                      r_in_ready;

  logic [10:0]               w_mag;
  logic signed [ACC_W-1:0]   w_mag_ext;
  logic signed [ACC_W-1:0]   w_val;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_result;
  logic                      w_accept;
  logic                      w_last;

  // The largest code (F=15, E=7) gives 1920, which fits in 11 bits. A negative
  // zero (S=1, F=0) negates to 0, so no special case is needed.
  assign w_mag     = {7'b0, in_f} << in_e;
  assign w_mag_ext = $signed({{(ACC_W-11){1'b0}}, w_mag});
  assign w_val     = in_s ? -w_mag_ext : w_mag_ext;
  assign w_sum     = r_acc + w_val;

`ifdef FP_WINDOW_ACC_MEAN_EN
  // Arithmetic shift rounds toward minus infinity. This is the intended floor mean.
  assign w_result = w_sum >>> WIN_LOG2;
`else
  assign w_result = w_sum;
`endif

  // in_ready is a registered copy of the state. This keeps it off any
  // combinational path from in_valid or out_ready.
  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_count == {WIN_LOG2{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              // The final sample goes straight into the output register.
              // The accumulator restarts clean for the next window.
              r_out_sum   <= w_result;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_count     <= '0;
              r_in_ready  <= 1'b0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc   <= w_sum;
              r_count <= r_count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ACCUM;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;

endmodule
